lsu_arbiter: RTL and testbench
==============================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous and active-low.
REQ-004 i_mX_req  in  1  (X=0 core MEM stage, X=1 loader/debug port) access request; held until granted.
REQ-005 i_mX_wren  in  1  1 = store, 0 = load.
REQ-006 i_mX_addr  in  32  byte address.
REQ-007 i_mX_data  in  32  store data.
REQ-008 i_mX_slt_sl  in  3  access type: SB=000, SH=001, SW=010, LB=011, LH=100, LW=101, LBU=110, LHU=111.
REQ-009 o_mX_gnt  out  1  request accepted this cycle; fields sampled this edge.
REQ-010 o_mX_rvalid  out  1  one-cycle completion pulse, loads and stores.
REQ-011 o_mX_rdata  out  32  load data, valid with rvalid; 0 for stores/errors.
REQ-012 o_mX_err  out  1  illegal access flag, valid with rvalid.
REQ-013 o_lsu_wren, o_lsu_addr[31:0], o_st_data[31:0], o_slt_sl[2:0]  out  registered LSU command.
REQ-014 i_ld_data  in  32  LSU load result, combinational from o_lsu_addr.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any grant, ACCESS->RESP always, RESP->IDLE always.
REQ-016 Grants issued only in IDLE, at most one per cycle, combinational from i_mX_req.
REQ-017 RR_EN=1: both requesting -> grant requester not granted last; priority pointer flips after each grant; pointer resets to requester 0.
REQ-018 RR_EN=0: both requesting -> requester 0 always wins.
REQ-019 Single requester: granted in the first IDLE cycle regardless of pointer.
REQ-020 On grant edge, winner's wren/addr/data/slt_sl latched into LSU command registers and owner ID stored.
REQ-021 LSU command registers driven during ACCESS only; o_lsu_wren high exactly one cycle (ACCESS) for legal stores.
REQ-022 Outside ACCESS, o_lsu_wren = 0; addr/data/slt_sl hold last value.
REQ-023 i_ld_data captured at end of ACCESS; owner's rvalid/rdata/err asserted in RESP; other requester's outputs remain 0.
REQ-024 Latency: grant cycle N, LSU access N+1, rvalid N+2; next grant earliest N+3.
REQ-025 Legal ranges: 0x0000_0000-0x0000_FFFF (RAM, R/W), 0x1000_0000-0x1000_4FFF (output buffer, R/W), 0x1001_0000-0x1001_0FFF (switch, read-only).
REQ-026 Out-of-range access, or store to switch range: o_lsu_wren stays 0, rdata = 0, err = 1 at rvalid.
REQ-027 Misaligned SW/LW (addr[1:0]!=0) or SH/LH/LHU (addr[0]=1): treated as illegal per REQ-026.
REQ-028 Request dropped before grant: no grant, no side effect; drop after grant irrelevant (transaction completes).
REQ-029 Requester may re-request in RESP cycle; granted in following IDLE.

Reset
REQ-030 Reset asserted: state = IDLE, pointer = requester 0, all outputs and command registers 0, captured data 0.
REQ-031 Reset mid-ACCESS/RESP: transaction aborted, no rvalid issued, o_lsu_wren drops immediately (async).
REQ-032 First grant possible in first cycle after reset release.

Structure
REQ-033 Shared package lsu_pkg holds slt_sl encodings, address-map constants, FSM state enum.
REQ-034 One sub-module lsu_addr_chk: combinational legality check (range, read-only, alignment) -> legal flag.
REQ-035 Core of arbiter: FSM, priority pointer, command/response registers; no memories.

Verification
REQ-036 m0 SW addr 0x0000_0010 data 0xDEAD_BEEF, then m0 LW same addr -> o_lsu_wren high one cycle; second rvalid at N+2 with rdata 0xDEAD_BEEF, err 0.
REQ-037 m0 and m1 continuously requesting, RR_EN=1 -> grants alternate m0,m1,m0,m1, one every 3 cycles; RR_EN=0 -> m0 only.
REQ-038 m1 SW to 0x1001_0000, m0 LW from 0x2000_0000 -> both err=1, rdata 0, o_lsu_wren never high.
REQ-039 m0 SH addr 0x0000_0003 -> err=1; SB addr 0x0000_0003 data 0x55 -> legal, later LBU returns 0x0000_0055.
REQ-040 i_reset_n low during ACCESS of a store -> o_lsu_wren low immediately, no rvalid; after release, pending m1 granted first cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU arbiter: access-type encodings, address map
// and the arbiter FSM state type.
package lsu_pkg;

    localparam logic [2:0] SLT_SB  = 3'b000;
    localparam logic [2:0] SLT_SH  = 3'b001;
    localparam logic [2:0] SLT_SW  = 3'b010;
    localparam logic [2:0] SLT_LB  = 3'b011;
    localparam logic [2:0] SLT_LH  = 3'b100;
    localparam logic [2:0] SLT_LW  = 3'b101;
    localparam logic [2:0] SLT_LBU = 3'b110;
    localparam logic [2:0] SLT_LHU = 3'b111;

    localparam logic [31:0] RAM_LO  = 32'h0000_0000;
    localparam logic [31:0] RAM_HI  = 32'h0000_FFFF;
    localparam logic [31:0] OBUF_LO = 32'h1000_0000;
    localparam logic [31:0] OBUF_HI = 32'h1000_4FFF;
    localparam logic [31:0] SWI_LO  = 32'h1001_0000;
    localparam logic [31:0] SWI_HI  = 32'h1001_0FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/lsu_addr_chk.sv
// Combinational legality check of one LSU access: address window,
// read-only switch window and natural alignment.
module lsu_addr_chk
    import lsu_pkg::*;
(
    input  logic        wren,
    input  logic [31:0] addr,
    input  logic [2:0]  slt_sl,
    output logic        legal
);

    logic in_ram_s;
    logic in_obuf_s;
    logic in_swi_s;
    logic misalign_s;

    // Window decode, alignment by access width, and the final verdict
    always_comb begin
        in_ram_s  = in_range(addr, RAM_LO, RAM_HI);
        in_obuf_s = in_range(addr, OBUF_LO, OBUF_HI);
        in_swi_s  = in_range(addr, SWI_LO, SWI_HI);
        case (slt_sl)
            SLT_SW, SLT_LW:          misalign_s = (addr[1:0] != 2'b00);
            SLT_SH, SLT_LH, SLT_LHU: misalign_s = addr[0];
            default:                 misalign_s = 1'b0;
        endcase
        legal = (in_ram_s || in_obuf_s || (in_swi_s && !wren)) && !misalign_s;
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of a single-ported LSU: grant in IDLE,
// one LSU access cycle, one response cycle back to the owner.
module lsu_arbiter
    import lsu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_slt_sl,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_slt_sl,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,
    output logic        o_lsu_wren,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [2:0]  o_slt_sl,
    input  logic [31:0] i_ld_data
);

    state_e      state_r;
    logic        ptr_r;
    logic        owner_r;
    logic        legal_r;
    logic        cmd_store_r;
    logic        lsu_wren_r;
    logic [31:0] lsu_addr_r;
    logic [31:0] st_data_r;
    logic [2:0]  slt_sl_r;
    logic        m0_rvalid_r;
    logic [31:0] m0_rdata_r;
    logic        m0_err_r;
    logic        m1_rvalid_r;
    logic [31:0] m1_rdata_r;
    logic        m1_err_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        win_wren_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_data_s;
    logic [2:0]  win_slt_sl_s;
    logic        win_legal_s;
    logic [31:0] resp_data_s;

    // Grant decision: only in IDLE; ptr_r names the requester favoured on contention
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (i_m0_req && i_m1_req) begin
                if (RR_EN && ptr_r) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end else begin
                gnt0_s = i_m0_req;
                gnt1_s = i_m1_req;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Winner's command fields, fed to the legality check and the command registers
    always_comb begin
        if (gnt1_s) begin
            win_wren_s   = i_m1_wren;
            win_addr_s   = i_m1_addr;
            win_data_s   = i_m1_data;
            win_slt_sl_s = i_m1_slt_sl;
        end else begin
            win_wren_s   = i_m0_wren;
            win_addr_s   = i_m0_addr;
            win_data_s   = i_m0_data;
            win_slt_sl_s = i_m0_slt_sl;
        end
    end

    lsu_addr_chk u_addr_chk (
        .wren   (win_wren_s),
        .addr   (win_addr_s),
        .slt_sl (win_slt_sl_s),
        .legal  (win_legal_s)
    );

    // Stores and illegal accesses return zero data
    always_comb begin
        if (legal_r && !cmd_store_r) begin
            resp_data_s = i_ld_data;
        end else begin
            resp_data_s = 32'h0000_0000;
        end
    end

    // Arbiter FSM with priority pointer, LSU command and per-requester response registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 1'b0;
            owner_r     <= 1'b0;
            legal_r     <= 1'b0;
            cmd_store_r <= 1'b0;
            lsu_wren_r  <= 1'b0;
            lsu_addr_r  <= 32'h0000_0000;
            st_data_r   <= 32'h0000_0000;
            slt_sl_r    <= 3'b000;
            m0_rvalid_r <= 1'b0;
            m0_rdata_r  <= 32'h0000_0000;
            m0_err_r    <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m1_rdata_r  <= 32'h0000_0000;
            m1_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt0_s || gnt1_s) begin
                        state_r     <= ST_ACCESS;
                        owner_r     <= gnt1_s;
                        ptr_r       <= gnt0_s;
                        legal_r     <= win_legal_s;
                        cmd_store_r <= win_wren_s;
                        lsu_wren_r  <= win_wren_s && win_legal_s;
                        lsu_addr_r  <= win_addr_s;
                        st_data_r   <= win_data_s;
                        slt_sl_r    <= win_slt_sl_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r    <= ST_RESP;
                    lsu_wren_r <= 1'b0;
                    if (owner_r) begin
                        m1_rvalid_r <= 1'b1;
                        m1_rdata_r  <= resp_data_s;
                        m1_err_r    <= !legal_r;
                    end else begin
                        m0_rvalid_r <= 1'b1;
                        m0_rdata_r  <= resp_data_s;
                        m0_err_r    <= !legal_r;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    m0_rvalid_r <= 1'b0;
                    m0_rdata_r  <= 32'h0000_0000;
                    m0_err_r    <= 1'b0;
                    m1_rvalid_r <= 1'b0;
                    m1_rdata_r  <= 32'h0000_0000;
                    m1_err_r    <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    lsu_wren_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_m0_gnt    = gnt0_s;
    assign o_m1_gnt    = gnt1_s;
    assign o_m0_rvalid = m0_rvalid_r;
    assign o_m0_rdata  = m0_rdata_r;
    assign o_m0_err    = m0_err_r;
    assign o_m1_rvalid = m1_rvalid_r;
    assign o_m1_rdata  = m1_rdata_r;
    assign o_m1_err    = m1_err_r;
    assign o_lsu_wren  = lsu_wren_r;
    assign o_lsu_addr  = lsu_addr_r;
    assign o_st_data   = st_data_r;
    assign o_slt_sl    = slt_sl_r;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter with a small byte-memory LSU model and
// a scoreboard of expected responses.
module tb_lsu_arbiter;

    localparam logic [2:0] T_SB  = 3'b000;
    localparam logic [2:0] T_SH  = 3'b001;
    localparam logic [2:0] T_SW  = 3'b010;
    localparam logic [2:0] T_LH  = 3'b100;
    localparam logic [2:0] T_LW  = 3'b101;
    localparam logic [2:0] T_LBU = 3'b110;
    localparam logic [2:0] T_LHU = 3'b111;

    typedef struct packed {
        logic        port;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  slt;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_wr;
    } txn_t;

    typedef struct packed {
        logic        ok;
        int          lat;
        logic        quiet;
        logic [31:0] rdata;
        logic        err;
        int          wr;
    } obs_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_clr = 1'b1;
    logic        m0_req = 1'b0, m0_wren = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_data = 32'h0;
    logic [2:0]  m0_slt = 3'b000;
    logic        m1_req = 1'b0, m1_wren = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_data = 32'h0;
    logic [2:0]  m1_slt = 3'b000;
    logic        gnt0, gnt1, rv0, rv1, err0, err1, lsu_wren;
    logic [31:0] rdata0, rdata1, lsu_addr, st_data, ld_data;
    logic [2:0]  slt_sl;
    logic        fp_gnt0, fp_gnt1, fp_rv0, fp_rv1, fp_err0, fp_err1, fp_wren;
    logic [31:0] fp_rdata0, fp_rdata1, fp_addr, fp_st_data;
    logic [2:0]  fp_slt;

    logic [7:0]  mem [256];
    logic [7:0]  ld_idx, b0, b1, b2, b3;
    int          cyc = 0;
    int          wren_cycles = 0;
    int          checks = 0;
    int          errors = 0;
    sb_t         sbq[$];

    always #5 clk = ~clk;

    lsu_arbiter #(.RR_EN(1'b1)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_data(m0_data), .i_m0_slt_sl(m0_slt),
        .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rdata0), .o_m0_err(err0),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_data(m1_data), .i_m1_slt_sl(m1_slt),
        .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rdata1), .o_m1_err(err1),
        .o_lsu_wren(lsu_wren), .o_lsu_addr(lsu_addr), .o_st_data(st_data),
        .o_slt_sl(slt_sl), .i_ld_data(ld_data)
    );

    lsu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_data(m0_data), .i_m0_slt_sl(m0_slt),
        .o_m0_gnt(fp_gnt0), .o_m0_rvalid(fp_rv0), .o_m0_rdata(fp_rdata0), .o_m0_err(fp_err0),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_data(m1_data), .i_m1_slt_sl(m1_slt),
        .o_m1_gnt(fp_gnt1), .o_m1_rvalid(fp_rv1), .o_m1_rdata(fp_rdata1), .o_m1_err(fp_err1),
        .o_lsu_wren(fp_wren), .o_lsu_addr(fp_addr), .o_st_data(fp_st_data),
        .o_slt_sl(fp_slt), .i_ld_data(32'h0000_0000)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (lsu_wren) wren_cycles <= wren_cycles + 1;

    // Little-endian byte memory standing in for the LSU
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (lsu_wren) begin
            mem[lsu_addr[7:0]] <= st_data[7:0];
            if (slt_sl != T_SB) mem[lsu_addr[7:0] + 8'd1] <= st_data[15:8];
            if (slt_sl == T_SW) begin
                mem[lsu_addr[7:0] + 8'd2] <= st_data[23:16];
                mem[lsu_addr[7:0] + 8'd3] <= st_data[31:24];
            end
        end
    end

    always_comb begin
        ld_idx = lsu_addr[7:0];
        b0 = mem[ld_idx];
        b1 = mem[ld_idx + 8'd1];
        b2 = mem[ld_idx + 8'd2];
        b3 = mem[ld_idx + 8'd3];
        case (slt_sl)
            3'b011:  ld_data = {{24{b0[7]}}, b0};
            3'b100:  ld_data = {{16{b1[7]}}, b1, b0};
            3'b101:  ld_data = {b3, b2, b1, b0};
            3'b110:  ld_data = {24'h0, b0};
            3'b111:  ld_data = {16'h0, b1, b0};
            default: ld_data = 32'h0;
        endcase
    end

    task automatic set_req(input logic port, input logic req, input txn_t t);
        if (port) begin
            m1_req = req; m1_wren = t.wren; m1_addr = t.addr; m1_data = t.data; m1_slt = t.slt;
        end else begin
            m0_req = req; m0_wren = t.wren; m0_addr = t.addr; m0_data = t.data; m0_slt = t.slt;
        end
    endtask

    // Driver: one request on one port, observes grant, latency and response
    task automatic run_txn(input txn_t t, output obs_t o);
        int g;
        int w0;
        o = '0;
        w0 = wren_cycles;
        sbq.push_back('{t.port, t.exp_rdata, t.exp_err});
        @(negedge clk);
        set_req(t.port, 1'b1, t);
        g = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((t.port ? gnt1 : gnt0) === 1'b1) begin
                g = cyc;
                break;
            end
            @(negedge clk);
        end
        if (g >= 0) @(posedge clk);
        @(negedge clk);
        set_req(t.port, 1'b0, t);
        if (g >= 0) begin
            for (int k = 0; k < 10; k++) begin
                if ((t.port ? rv1 : rv0) === 1'b1) begin
                    o.ok    = 1'b1;
                    o.lat   = cyc - g;
                    o.rdata = t.port ? rdata1 : rdata0;
                    o.err   = t.port ? err1 : err0;
                    o.quiet = t.port ? !(rv0 | err0 | (|rdata0)) : !(rv1 | err1 | (|rdata1));
                    break;
                end
                @(negedge clk);
            end
        end
        o.wr = wren_cycles - w0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((gnt0 | gnt1 | rv0 | rv1 | err0 | err1 | lsu_wren) !== 1'b0 || rdata0 !== 32'h0 ||
            rdata1 !== 32'h0 || lsu_addr !== 32'h0 || st_data !== 32'h0 || slt_sl !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: gnt=%b%b rv=%b%b err=%b%b wren=%b rdata=%h/%h addr=%h data=%h slt=%b, expected all 0",
                     gnt0, gnt1, rv0, rv1, err0, err1, lsu_wren, rdata0, rdata1, lsu_addr, st_data, slt_sl);
        end
        mem_clr = 1'b0;
        m0_wren = 1'b0; m0_addr = 32'h0; m0_slt = T_LW; m0_req = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL first_grant_after_reset: gnt0=%b gnt1=%b, expected 1 0", gnt0, gnt1);
        end
        @(posedge clk);
        @(negedge clk);
        m0_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_store_load();
        txn_t tab[$];
        obs_t o;
        sb_t  e;
        tab.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, T_SW, 32'h0, 1'b0, 1'b1});
        tab.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0, T_LW, 32'hDEAD_BEEF, 1'b0, 1'b0});
        for (int i = 0; i < tab.size(); i++) begin
            run_txn(tab[i], o);
            e = sbq.pop_front();
            checks++;
            if (!o.ok || o.lat != 2 || !o.quiet || o.rdata !== e.rdata || o.err !== e.err || o.wr != int'(tab[i].exp_wr)) begin
                errors++;
                $display("FAIL store_load[%0d]: ok=%0b lat=%0d quiet=%0b rdata=%h err=%0b wr=%0d, expected rdata=%h err=%0b wr=%0d lat=2",
                         i, o.ok, o.lat, o.quiet, o.rdata, o.err, o.wr, e.rdata, e.err, tab[i].exp_wr);
            end
        end
        checks++;
        if (lsu_addr !== 32'h0000_0010 || slt_sl !== T_LW || lsu_wren !== 1'b0) begin
            errors++;
            $display("FAIL cmd_hold: addr=%h slt=%b wren=%b, expected 00000010 101 0", lsu_addr, slt_sl, lsu_wren);
        end
    endtask

    task automatic test_illegal();
        txn_t tab[$];
        obs_t o;
        sb_t  e;
        tab.push_back('{1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, T_SW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b0, 1'b0, 32'h2000_0000, 32'h0, T_LW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b1, 1'b1, 32'h1000_0040, 32'hCAFE_F00D, T_SW, 32'h0, 1'b0, 1'b1});
        tab.push_back('{1'b0, 1'b0, 32'h1000_0040, 32'h0, T_LW, 32'hCAFE_F00D, 1'b0, 1'b0});
        tab.push_back('{1'b1, 1'b0, 32'h1001_0FFC, 32'h0, T_LW, 32'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, 1'b0, 32'h1001_1000, 32'h0, T_LW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b0, 1'b0, 32'h1000_5000, 32'h0, T_LW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b0, 1'b1, 32'h1000_4FFF, 32'h0, T_SB, 32'h0, 1'b0, 1'b1});
        tab.push_back('{1'b1, 1'b0, 32'h0001_0000, 32'h0, T_LW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b1, 1'b0, 32'h0000_FFFC, 32'h0, T_LW, 32'h0, 1'b0, 1'b0});
        for (int i = 0; i < tab.size(); i++) begin
            run_txn(tab[i], o);
            e = sbq.pop_front();
            checks++;
            if (!o.ok || o.lat != 2 || !o.quiet || o.rdata !== e.rdata || o.err !== e.err || o.wr != int'(tab[i].exp_wr)) begin
                errors++;
                $display("FAIL addr_map[%0d] addr=%h: ok=%0b lat=%0d quiet=%0b rdata=%h err=%0b wr=%0d, expected rdata=%h err=%0b wr=%0d",
                         i, tab[i].addr, o.ok, o.lat, o.quiet, o.rdata, o.err, o.wr, e.rdata, e.err, tab[i].exp_wr);
            end
        end
    endtask

    task automatic test_align();
        txn_t tab[$];
        obs_t o;
        sb_t  e;
        tab.push_back('{1'b0, 1'b1, 32'h0000_0003, 32'h0000_1234, T_SH, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0055, T_SB, 32'h0, 1'b0, 1'b1});
        tab.push_back('{1'b0, 1'b0, 32'h0000_0003, 32'h0, T_LBU, 32'h0000_0055, 1'b0, 1'b0});
        tab.push_back('{1'b0, 1'b0, 32'h0000_0002, 32'h0, T_LW, 32'h0, 1'b1, 1'b0});
        tab.push_back('{1'b1, 1'b0, 32'h0000_0002, 32'h0, T_LHU, 32'h0000_5500, 1'b0, 1'b0});
        tab.push_back('{1'b1, 1'b0, 32'h0000_0001, 32'h0, T_LH, 32'h0, 1'b1, 1'b0});
        for (int i = 0; i < tab.size(); i++) begin
            run_txn(tab[i], o);
            e = sbq.pop_front();
            checks++;
            if (!o.ok || o.lat != 2 || !o.quiet || o.rdata !== e.rdata || o.err !== e.err || o.wr != int'(tab[i].exp_wr)) begin
                errors++;
                $display("FAIL align[%0d] addr=%h slt=%b: ok=%0b lat=%0d rdata=%h err=%0b wr=%0d, expected rdata=%h err=%0b wr=%0d",
                         i, tab[i].addr, tab[i].slt, o.ok, o.lat, o.rdata, o.err, o.wr, e.rdata, e.err, tab[i].exp_wr);
            end
        end
    endtask

    task automatic test_round_robin();
        int gq[$];
        int last, seen, fp0, fp1, both, exp_port, k;
        apply_reset();
        gq = '{0, 1, 0, 1};
        m0_wren = 1'b0; m0_addr = 32'h10; m0_slt = T_LW;
        m1_wren = 1'b0; m1_addr = 32'h10; m1_slt = T_LW;
        m0_req = 1'b1; m1_req = 1'b1;
        last = -1; seen = 0; fp0 = 0; fp1 = 0; both = 0; k = 0;
        while (k < 30 && seen < 4) begin
            #1;
            if (gnt0 && gnt1) both++;
            if (fp_gnt0) fp0++;
            if (fp_gnt1) fp1++;
            if (gnt0 || gnt1) begin
                exp_port = gq.pop_front();
                checks++;
                if (gnt1 !== exp_port[0] || (last >= 0 && cyc - last != 3) || (last < 0 && k != 0)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: port=%0d gap=%0d, expected port=%0d gap=3",
                             seen, gnt1, (last >= 0) ? cyc - last : k, exp_port);
                end
                last = cyc;
                seen++;
            end
            if (seen < 4) @(negedge clk);
            k++;
        end
        checks++;
        if (seen != 4 || both != 0) begin
            errors++;
            $display("FAIL rr_count: grants=%0d double=%0d, expected 4 0", seen, both);
        end
        checks++;
        if (fp0 != 4 || fp1 != 0) begin
            errors++;
            $display("FAIL fixed_prio: m0_grants=%0d m1_grants=%0d, expected 4 0", fp0, fp1);
        end
        @(posedge clk);
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int g1[$];
        int m0_seen, rv1_seen;
        sb_t e;
        m0_seen = 0; rv1_seen = 0;
        sbq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
        sbq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        m1_wren = 1'b0; m1_addr = 32'h10; m1_slt = T_LW; m1_req = 1'b1;
        m0_wren = 1'b1; m0_addr = 32'h30; m0_data = 32'h0BAD_0BAD; m0_slt = T_SW;
        for (int t = 0; t < 9; t++) begin
            if (t == 1) m0_req = 1'b1;
            if (t == 2) m0_req = 1'b0;
            if (t == 4) m1_req = 1'b0;
            #1;
            if (gnt1) g1.push_back(t);
            if (gnt0 || rv0) m0_seen++;
            if (rv1) begin
                rv1_seen++;
                e = sbq.pop_front();
                checks++;
                if (rdata1 !== e.rdata || err1 !== e.err) begin
                    errors++;
                    $display("FAIL b2b_resp: rdata=%h err=%0b, expected %h %0b", rdata1, err1, e.rdata, e.err);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (g1.size() != 2 || rv1_seen != 2) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d responses=%0d, expected 2 2", g1.size(), rv1_seen);
        end else if (g1[0] != 0 || g1[1] != 3) begin
            errors++;
            $display("FAIL b2b_timing: grant cycles %0d %0d, expected 0 3", g1[0], g1[1]);
        end
        checks++;
        if (m0_seen != 0 || wren_cycles != 4) begin
            errors++;
            $display("FAIL dropped_req: m0 activity=%0d store cycles=%0d, expected 0 4", m0_seen, wren_cycles);
        end
        while (sbq.size() > 0) void'(sbq.pop_front());
    endtask

    task automatic test_reset_abort();
        int   rv_seen;
        int   k;
        txn_t t;
        obs_t o;
        sb_t  e;
        rv_seen = 0;
        @(negedge clk);
        m0_wren = 1'b1; m0_addr = 32'h20; m0_data = 32'h1122_3344; m0_slt = T_SW; m0_req = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant: gnt0=%b, expected 1", gnt0);
        end
        @(posedge clk);
        @(negedge clk);
        m0_req = 1'b0;
        checks++;
        if (lsu_wren !== 1'b1) begin
            errors++;
            $display("FAIL abort_access_wren: wren=%b, expected 1", lsu_wren);
        end
        #2;
        m1_wren = 1'b0; m1_addr = 32'h10; m1_slt = T_LW; m1_req = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (lsu_wren !== 1'b0) begin
            errors++;
            $display("FAIL abort_wren_drop: wren=%b, expected 0", lsu_wren);
        end
        repeat (3) begin
            @(negedge clk);
            if (rv0 || rv1) rv_seen++;
        end
        sbq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rv_seen != 0) begin
            errors++;
            $display("FAIL abort_release: gnt1=%b gnt0=%b rvalids_in_reset=%0d, expected 1 0 0", gnt1, gnt0, rv_seen);
        end
        @(posedge clk);
        @(negedge clk);
        m1_req = 1'b0;
        k = 0;
        while (k < 6 && rv1 !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        e = sbq.pop_front();
        checks++;
        if (rv1 !== 1'b1 || rdata1 !== e.rdata || err1 !== e.err || rv0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_pending_m1: rvalid=%b rdata=%h err=%b m0_rvalid=%b, expected 1 %h %b 0",
                     rv1, rdata1, err1, rv0, e.rdata, e.err);
        end
        t = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, T_LW, 32'h0, 1'b0, 1'b0};
        run_txn(t, o);
        e = sbq.pop_front();
        checks++;
        if (!o.ok || o.rdata !== e.rdata || o.err !== e.err) begin
            errors++;
            $display("FAIL abort_no_store: ok=%0b rdata=%h err=%0b, expected rdata=%h err=%0b",
                     o.ok, o.rdata, o.err, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_illegal();
        test_align();
        test_round_robin();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
